// File: rtl/serial2parallel_lanes_pkg.sv
// Shared types and elaboration helpers for the lane-parallel deserialiser.
// Parameter legality is checked where the parameters are known (top level).
package serial2parallel_pkg;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    function automatic int unsigned beats(input int unsigned word_w, input int unsigned lanes);
        return word_w / lanes;
    endfunction

    function automatic bit lanes_ok(input int unsigned word_w, input int unsigned lanes);
        return (lanes != 0) && (word_w >= lanes) && ((word_w % lanes) == 0);
    endfunction

endpackage

// File: rtl/serial2parallel_lanes_if.sv
// Beat input, word output handshake and error pulses of the deserialiser.
interface serial2parallel_lanes_if #(
    parameter int unsigned WORD_W = 8,
    parameter int unsigned LANES  = 1
);
    logic [LANES-1:0]  din;
    logic              din_valid;
    logic              din_sync;
    logic [WORD_W-1:0] dout;
    logic              dout_valid;
    logic              dout_ready;
    logic              overflow;
    logic              sync_err;

    modport master (
        output din, din_valid, din_sync, dout_ready,
        input  dout, dout_valid, overflow, sync_err
    );

    modport slave (
        input  din, din_valid, din_sync, dout_ready,
        output dout, dout_valid, overflow, sync_err
    );
endinterface

// File: rtl/serial2parallel_lanes_out_slice.sv
// Single-entry valid/ready holding register; a load while full and not drained
// is dropped and reported by a one-cycle drop pulse.
import serial2parallel_pkg::*;

module s2p_out_slice #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] data,
    output logic         drop
);
    slot_state_e  state_q, state_d;
    logic [W-1:0] data_q, data_d;
    logic         drop_q, drop_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SLOT_EMPTY;
            data_q  <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            drop_q  <= drop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        drop_d  = 1'b0;
        case (state_q)
            SLOT_EMPTY: begin
                if (load) begin
                    state_d = SLOT_FULL;
                    data_d  = load_data;
                end
            end
            SLOT_FULL: begin
                // Drain and refill on the same edge keeps back-to-back throughput.
                if (ready) begin
                    if (load) begin
                        data_d = load_data;
                    end else begin
                        state_d = SLOT_EMPTY;
                    end
                end else if (load) begin
                    drop_d = 1'b1;
                end
            end
            default: state_d = SLOT_EMPTY;
        endcase
    end

    assign valid = (state_q == SLOT_FULL);
    assign data  = data_q;
    assign drop  = drop_q;
endmodule

// File: rtl/serial2parallel_lanes.sv
// Lane-parallel serial-to-parallel deserialiser: beat counter, shift register,
// frame-sync realignment and a registered output slice with overflow reporting.
import serial2parallel_pkg::*;

module serial2parallel_lanes #(
    parameter int unsigned WORD_W    = 8,
    parameter int unsigned LANES     = 1,
    parameter int unsigned MSB_FIRST = 1
) (
    input logic                    clk,
    input logic                    rst,
    serial2parallel_lanes_if.slave bus
);
    localparam int unsigned BEATS = beats(WORD_W, LANES);
    localparam int unsigned CNT_W = $clog2(BEATS) + 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    if (!lanes_ok(WORD_W, LANES)) begin : g_param_check
        $error("serial2parallel_lanes: WORD_W must be a non-zero multiple of LANES");
    end

    logic [CNT_W-1:0]        cnt_q, cnt_d, beat_idx;
    logic [WORD_W-1:0]       shift_q, shift_d, base;
    logic [WORD_W+LANES-1:0] ext;
    logic                    complete;
    logic                    sync_err_q, sync_err_d;
    logic                    slice_valid, slice_drop;
    logic [WORD_W-1:0]       slice_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            shift_q    <= '0;
            sync_err_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            sync_err_q <= sync_err_d;
        end
    end

    always_comb begin
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        sync_err_d = 1'b0;
        complete   = 1'b0;
        beat_idx   = cnt_q;
        base       = shift_q;
        ext        = '0;
        if (bus.din_valid) begin
            // A sync beat restarts the word from an empty shift register.
            if (bus.din_sync) begin
                beat_idx   = '0;
                base       = '0;
                sync_err_d = (cnt_q != '0);
            end
            if (MSB_FIRST != 0) begin
                ext     = {base, bus.din};
                shift_d = ext[WORD_W-1:0];
            end else begin
                ext     = {bus.din, base};
                shift_d = ext[WORD_W+LANES-1:LANES];
            end
            complete = (beat_idx == LAST_BEAT);
            cnt_d    = complete ? '0 : beat_idx + 1'b1;
        end
    end

    s2p_out_slice #(.W(WORD_W)) u_out_slice (
        .clk       (clk),
        .rst       (rst),
        .load      (complete),
        .load_data (shift_d),
        .ready     (bus.dout_ready),
        .valid     (slice_valid),
        .data      (slice_data),
        .drop      (slice_drop)
    );

    assign bus.dout       = slice_data;
    assign bus.dout_valid = slice_valid;
    assign bus.overflow   = slice_drop;
    assign bus.sync_err   = sync_err_q;
endmodule

// File: tb/tb_serial2parallel_lanes.sv
// Directed checks of two deserialiser configurations: 8x1 MSB-first and 8x4 LSB-first.
module tb_serial2parallel_lanes;
    logic clk = 1'b0;
    logic rst_a, rst_b;
    int   n_asserts = 0;
    int   n_fail    = 0;

    always #5 clk = ~clk;

    serial2parallel_lanes_if #(.WORD_W(8), .LANES(1)) ifa ();
    serial2parallel_lanes_if #(.WORD_W(8), .LANES(4)) ifb ();

    serial2parallel_lanes #(.WORD_W(8), .LANES(1), .MSB_FIRST(1)) u_dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (ifa)
    );

    serial2parallel_lanes #(.WORD_W(8), .LANES(4), .MSB_FIRST(0)) u_dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (ifb)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_asserts++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat_a(input logic b, input logic s);
        ifa.din       = b;
        ifa.din_valid = 1'b1;
        ifa.din_sync  = s;
        tick();
        ifa.din_valid = 1'b0;
        ifa.din_sync  = 1'b0;
    endtask

    task automatic beat_b(input logic [3:0] d, input logic s);
        ifb.din       = d;
        ifb.din_valid = 1'b1;
        ifb.din_sync  = s;
        tick();
        ifb.din_valid = 1'b0;
        ifb.din_sync  = 1'b0;
    endtask

    task automatic word_a(input logic [7:0] w, input int unsigned nbits);
        for (int i = 7; i > 7 - int'(nbits); i--) beat_a(w[i], 1'b0);
    endtask

    initial begin
        logic [7:0] w;
        rst_a = 1'b1; rst_b = 1'b1;
        ifa.din = '0; ifa.din_valid = 1'b0; ifa.din_sync = 1'b0; ifa.dout_ready = 1'b1;
        ifb.din = '0; ifb.din_valid = 1'b0; ifb.din_sync = 1'b0; ifb.dout_ready = 1'b1;
        tick();
        check("a_rst_dout", ifa.dout, 8'h00);
        check("a_rst_valid", ifa.dout_valid, 1'b0);
        check("a_rst_ovf", ifa.overflow, 1'b0);
        check("a_rst_serr", ifa.sync_err, 1'b0);
        check("b_rst_valid", ifb.dout_valid, 1'b0);
        rst_a = 1'b0; rst_b = 1'b0;

        // 1: A5 MSB-first, valid only after the 8th beat
        word_a(8'hA5, 7);
        check("t1_valid_7beats", ifa.dout_valid, 1'b0);
        beat_a(1'b1, 1'b0);
        check("t1_valid", ifa.dout_valid, 1'b1);
        check("t1_dout", ifa.dout, 8'hA5);
        tick();
        check("t1_drained", ifa.dout_valid, 1'b0);

        // 3: hold first word, drop second with one overflow pulse
        ifa.dout_ready = 1'b0;
        word_a(8'h3C, 8);
        check("t3_valid1", ifa.dout_valid, 1'b1);
        check("t3_ovf_first", ifa.overflow, 1'b0);
        word_a(8'h96, 8);
        check("t3_ovf", ifa.overflow, 1'b1);
        check("t3_held", ifa.dout, 8'h3C);
        tick();
        check("t3_ovf_pulse", ifa.overflow, 1'b0);
        check("t3_still_valid", ifa.dout_valid, 1'b1);
        ifa.dout_ready = 1'b1;
        tick();
        check("t3_once", ifa.dout_valid, 1'b0);

        // 4: sync on 4th beat realigns the word
        beat_a(1'b1, 1'b0); beat_a(1'b1, 1'b0); beat_a(1'b1, 1'b0);
        beat_a(1'b0, 1'b1);
        check("t4_serr", ifa.sync_err, 1'b1);
        beat_a(1'b1, 1'b0);
        check("t4_serr_pulse", ifa.sync_err, 1'b0);
        w = 8'h5A;
        for (int i = 5; i >= 0; i--) beat_a(w[i], 1'b0);
        check("t4_valid", ifa.dout_valid, 1'b1);
        check("t4_dout", ifa.dout, 8'h5A);
        tick();

        // 5: reset mid-word and with a held word
        word_a(8'hFF, 5);
        rst_a = 1'b1; tick(); rst_a = 1'b0;
        check("t5_rst_dout", ifa.dout, 8'h00);
        check("t5_rst_valid", ifa.dout_valid, 1'b0);
        ifa.dout_ready = 1'b0;
        word_a(8'h77, 8);
        check("t5_held_valid", ifa.dout_valid, 1'b1);
        rst_a = 1'b1; tick(); rst_a = 1'b0;
        check("t5_rst2_dout", ifa.dout, 8'h00);
        check("t5_rst2_valid", ifa.dout_valid, 1'b0);
        check("t5_rst2_ovf", ifa.overflow, 1'b0);
        check("t5_rst2_serr", ifa.sync_err, 1'b0);
        ifa.dout_ready = 1'b1;
        word_a(8'hC3, 7);
        check("t5_no_early", ifa.dout_valid, 1'b0);
        beat_a(1'b1, 1'b0);
        check("t5_clean", ifa.dout, 8'hC3);
        tick();

        // 6: completion and ready together while full
        ifa.dout_ready = 1'b0;
        word_a(8'h11, 8);
        check("t6_old", ifa.dout, 8'h11);
        w = 8'hEE;
        for (int i = 7; i >= 1; i--) beat_a(w[i], 1'b0);
        ifa.dout_ready = 1'b1;
        beat_a(w[0], 1'b0);
        check("t6_new", ifa.dout, 8'hEE);
        check("t6_valid", ifa.dout_valid, 1'b1);
        check("t6_ovf", ifa.overflow, 1'b0);
        tick();
        check("t6_drained", ifa.dout_valid, 1'b0);

        // 2: 4 lanes, LSB-first, then back-to-back words
        beat_b(4'h3, 1'b0);
        beat_b(4'hC, 1'b0);
        check("t2_dout", ifb.dout, 8'hC3);
        check("t2_valid", ifb.dout_valid, 1'b1);
        for (int k = 0; k < 8; k++) begin
            beat_b(4'(2 * k), 1'b0);
            check("t2_gap_valid", ifb.dout_valid, 1'b0);
            beat_b(4'(2 * k + 1), 1'b0);
            check("t2_word", ifb.dout, 32'((2 * k + 1) * 16 + 2 * k));
            check("t2_word_valid", ifb.dout_valid, 1'b1);
            check("t2_ovf", ifb.overflow, 1'b0);
        end

        // sync on the second beat of a 2-beat word
        beat_b(4'h5, 1'b0);
        beat_b(4'h7, 1'b1);
        check("b_serr", ifb.sync_err, 1'b1);
        check("b_no_word", ifb.dout_valid, 1'b0);
        beat_b(4'h9, 1'b0);
        check("b_sync_word", ifb.dout, 8'h97);
        check("b_serr_pulse", ifb.sync_err, 1'b0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
